muldiv_unit: RTL

- Iterative multiply/divide unit in the EX stage, beside the ALU. It consumes the same A/B operands and holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over 32 iterations.
- Exposes busy so the control unit can stall any instruction that touches HI/LO until done.
- HI/LO feed the writeback mux for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO
//
// Purpose:
//   Multiply/divide unit beside the EX-stage ALU. A launched operation runs
//   IDLE -> RUN (32 shift-add or restoring shift-subtract steps) -> DONE -> IDLE.
//   Work is done on operand magnitudes. Signs are re-applied only in DONE.
//
// Optional feature:
//   MULDIV_FAST_MUL_EN - when defined, MULT/MULTU compute the product in one
//   cycle and go IDLE -> DONE directly. Divide is unchanged.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   launch an operation (sampled in IDLE only)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B   in   operands (rs, rt); A is also the mthi/mtlo source
//   mthi   in   write A into HI (IDLE only)
//   mtlo   in   write A into LO (IDLE only)
//   busy   out  high whenever not IDLE
//   done   out  one-cycle pulse; hi/lo show the new result in this cycle
//   hi, lo out  architectural HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               neg_q, neg_d;     // product / quotient is negative
   logic               rsign_q, rsign_d; // remainder takes dividend sign
   logic               divz_q, divz_d;   // divide by zero
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;     // product or remainder/quotient
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Operand magnitudes; unsigned ops pass the raw value through.
   logic             is_signed, sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      is_signed = ~op[0];
      sign_a    = is_signed & A[WIDTH-1];
      sign_b    = is_signed & B[WIDTH-1];
      mag_a     = sign_a ? -A : A;
      mag_b     = sign_b ? -B : B;
   end

   // Multiply step: conditionally add the multiplicand into the upper half,
   // then shift the (WIDTH+1)-bit sum and lower half right by one.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Restoring divide step: shift remainder:quotient left, trial-subtract the
   // divisor from the (WIDTH+1)-bit partial remainder, and shift in the
   // quotient bit. The kept remainder is always below the divisor, so the
   // WIDTH-bit subtraction never loses information.
   logic [WIDTH:0]     div_rem;
   logic               div_ge;
   logic [WIDTH-1:0]   div_upper;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      div_rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_rem >= {1'b0, opnd_q});
      div_upper = div_ge ? (div_rem[WIDTH-1:0] - opnd_q) : div_rem[WIDTH-1:0];
      div_next  = {div_upper, acc_q[WIDTH-2:0], div_ge};
   end

   // Final result with signs applied; only meaningful in DONE.
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_res, rem_res, res_hi, res_lo;

   always_comb begin
      prod_res = neg_q ? -acc_q : acc_q;
      rem_res  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      // Divide by zero yields all-ones regardless of operand signs; the
      // remainder path already returns the original dividend.
      if (divz_q) begin
         quo_res = {WIDTH{1'b1}};
      end else begin
         quo_res = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
      if (op_q[1]) begin
         res_hi = rem_res;
         res_lo = quo_res;
      end else begin
         res_hi = prod_res[2*WIDTH-1:WIDTH];
         res_lo = prod_res[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rsign_d = rsign_q;
      divz_d  = divz_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               neg_d   = sign_a ^ sign_b;
               rsign_d = sign_a;
               divz_d  = op[1] & (B == {WIDTH{1'b0}});
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_RUN;
               if (op[1]) begin
                  opnd_d = mag_b;
                  acc_d  = {{WIDTH{1'b0}}, mag_a};
               end else begin
                  opnd_d = mag_a;
                  acc_d  = {{WIDTH{1'b0}}, mag_b};
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                  state_d = S_DONE;
`endif
               end
            end else begin
               // start takes priority; a move in the same cycle is dropped.
               if (mthi) hi_d = A;
               if (mtlo) lo_d = A;
            end
         end

         S_RUN: begin
            acc_d = op_q[1] ? div_next : mul_next;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_DONE: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         op_q    <= 2'b00;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         divz_q  <= 1'b0;
         opnd_q  <= {WIDTH{1'b0}};
         acc_q   <= {(2*WIDTH){1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         divz_q  <= divz_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // In DONE the new result is presented directly; the registers take it
   // on the DONE -> IDLE edge.
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign hi   = done ? res_hi : hi_q;
   assign lo   = done ? res_lo : lo_q;

endmodule
